// File: rtl/keypad_debounce_irq.sv
// Four-key keypad debouncer: each key has a 2-flop synchroniser, a debounce FSM and a
// one-cycle press interrupt. Define KEYPAD_AUTOREPEAT_EN to add per-key auto-repeat pulses.
module keypad_debounce_irq #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 5000000
) (
  input  logic       HCLK,
  input  logic       HRESETn,
  input  logic [3:0] col,
  output logic [3:0] key_interrupt,
  output logic [3:0] key_state
);

  // state    | meaning
  // IDLE     | key released and stable
  // PRESS_DB | press seen, counting stable pressed samples
  // HELD     | press accepted, key_state high
  // REL_DB   | release seen, counting stable released samples
  typedef enum logic [1:0] {IDLE, PRESS_DB, HELD, REL_DB} state_t;

  localparam logic [19:0] DB_LAST = 20'(DEBOUNCE_CYCLES - 1);

  logic [3:0] sync1, sync2, pressed_s;

  // Keypad columns idle high, so synchronisers reset to 1 (not pressed).
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      sync1 <= 4'hF;
      sync2 <= 4'hF;
    end else begin
      sync1 <= col;
      sync2 <= sync1;
    end
  end

  assign pressed_s = ~sync2;

  for (genvar k = 0; k < 4; k++) begin : g_key
    state_t      state;
    logic [19:0] cnt;
    logic        irq, held;
    logic        rpt_fire;

`ifdef KEYPAD_AUTOREPEAT_EN
    localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RPT_W   = $clog2(RPT_MAX + 1);
    localparam logic [RPT_W-1:0] DLY_LAST = RPT_W'(REPEAT_DELAY - 1);
    localparam logic [RPT_W-1:0] PER_LAST = RPT_W'(REPEAT_PERIOD - 1);

    logic [RPT_W-1:0] rpt_cnt;
    logic             rpt_after_first;

    assign rpt_fire = (state == HELD) && pressed_s[k] &&
                      (rpt_after_first ? (rpt_cnt == PER_LAST) : (rpt_cnt == DLY_LAST));

    // Counts only while stably HELD; REL_DB freezes it so a bounce resumes the count.
    always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
        rpt_cnt         <= '0;
        rpt_after_first <= 1'b0;
      end else if (state == PRESS_DB && pressed_s[k] && cnt == DB_LAST) begin
        rpt_cnt         <= '0;
        rpt_after_first <= 1'b0;
      end else if (state == HELD && pressed_s[k]) begin
        if (rpt_fire) begin
          rpt_cnt         <= '0;
          rpt_after_first <= 1'b1;
        end else begin
          rpt_cnt <= rpt_cnt + RPT_W'(1);
        end
      end
    end
`else
    assign rpt_fire = 1'b0;
`endif

    always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
        state <= IDLE;
        cnt   <= '0;
        irq   <= 1'b0;
        held  <= 1'b0;
      end else begin
        irq <= rpt_fire;
        case (state)
          IDLE: begin
            if (pressed_s[k]) begin
              state <= PRESS_DB;
              cnt   <= '0;
            end
          end
          PRESS_DB: begin
            if (!pressed_s[k]) begin
              state <= IDLE;
              cnt   <= '0;
            end else if (cnt == DB_LAST) begin
              state <= HELD;
              cnt   <= '0;
              irq   <= 1'b1;
              held  <= 1'b1;
            end else begin
              cnt <= cnt + 20'd1;
            end
          end
          HELD: begin
            if (!pressed_s[k]) begin
              state <= REL_DB;
              cnt   <= '0;
            end
          end
          REL_DB: begin
            if (pressed_s[k]) begin
              state <= HELD;
              cnt   <= '0;
            end else if (cnt == DB_LAST) begin
              state <= IDLE;
              cnt   <= '0;
              held  <= 1'b0;
            end else begin
              cnt <= cnt + 20'd1;
            end
          end
          default: begin
            state <= IDLE;
            cnt   <= '0;
          end
        endcase
      end
    end

    assign key_interrupt[k] = irq;
    assign key_state[k]     = held;
  end

endmodule

// File: tb/tb_keypad_debounce_irq.sv
// Bench for keypad_debounce_irq: run-length behavioural model checked every cycle,
// plus directed scenarios with hand-computed expectations (follows KEYPAD_AUTOREPEAT_EN).
module tb_keypad_debounce_irq;
  localparam int D  = 4;
  localparam int RD = 10;
  localparam int RP = 5;

`ifdef KEYPAD_AUTOREPEAT_EN
  localparam bit RPT_ON = 1'b1;
`else
  localparam bit RPT_ON = 1'b0;
`endif

  logic       HCLK = 1'b0;
  logic       HRESETn = 1'b0;
  logic [3:0] col = 4'hF;
  logic [3:0] key_interrupt, key_state;

  int checks = 0;
  int failures = 0;

  keypad_debounce_irq #(
    .DEBOUNCE_CYCLES(D),
    .REPEAT_DELAY(RD),
    .REPEAT_PERIOD(RP)
  ) dut (
    .HCLK(HCLK),
    .HRESETn(HRESETn),
    .col(col),
    .key_interrupt(key_interrupt),
    .key_state(key_state)
  );

  always #5 HCLK = ~HCLK;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Model: a key is accepted after D+1 consecutive pressed samples (2 cycles after col),
  // released after D+1 consecutive released samples; repeat time counts stable held samples.
  logic [3:0] m_s1 = 4'hF, m_s2 = 4'hF, exp_irq = 4'h0, m_held = 4'h0, ps;
  int run[4];
  int htime[4];
  int pulses[4];

  always @(posedge HCLK) begin
    if (!HRESETn) begin
      m_s1 = 4'hF; m_s2 = 4'hF; exp_irq = 4'h0; m_held = 4'h0;
      for (int k = 0; k < 4; k++) begin run[k] = 0; htime[k] = 0; end
    end else begin
      ps = ~m_s2; m_s2 = m_s1; m_s1 = col;
      for (int k = 0; k < 4; k++) begin
        exp_irq[k] = 1'b0;
        if (!m_held[k]) begin
          run[k] = ps[k] ? run[k] + 1 : 0;
          if (run[k] == D + 1) begin
            m_held[k] = 1'b1; run[k] = 0; htime[k] = 0; exp_irq[k] = 1'b1;
          end
        end else if (!ps[k]) begin
          run[k]++;
          if (run[k] == D + 1) begin m_held[k] = 1'b0; run[k] = 0; end
        end else begin
          if (run[k] == 0 && RPT_ON) begin
            htime[k]++;
            if (htime[k] == RD || (htime[k] > RD && (htime[k] - RD) % RP == 0))
              exp_irq[k] = 1'b1;
          end
          run[k] = 0;
        end
      end
    end
    #1;
    check("model_cycle", {key_interrupt, key_state}, {exp_irq, m_held});
  end

  always @(negedge HCLK)
    for (int k = 0; k < 4; k++) if (key_interrupt[k]) pulses[k]++;

  task automatic tick(input int n);
    repeat (n) @(negedge HCLK);
  endtask

  int p0, p1, p2;

  initial begin
    HRESETn = 1'b0; col = 4'hF;
    tick(2);
    check("reset_state", {key_interrupt, key_state}, 8'h00);
    HRESETn = 1'b1;
    tick(2);

    // Clean press of key 0: pulse after edge 6 only, state from edge 6.
    col = 4'b1110;
    tick(6); check("press_edge5", {key_interrupt, key_state}, 8'h00);
    tick(1); check("press_edge6", {key_interrupt, key_state}, 8'h11);
    tick(1); check("press_edge7", {key_interrupt, key_state}, 8'h01);
    col = 4'b1111;
    tick(6); check("release_edge5", {key_interrupt, key_state}, 8'h01);
    tick(1); check("release_edge6", {key_interrupt, key_state}, 8'h00);
    tick(4);

    // Glitch on key 1: three low samples are rejected.
    p0 = pulses[1];
    col = 4'b1101; tick(3);
    col = 4'b1111; tick(10);
    check("glitch_pulses", 8'(pulses[1] - p0), 8'h00);
    check("glitch_state", {key_interrupt, key_state}, 8'h00);

    // Release bounce on key 2.
    p1 = pulses[2];
    col = 4'b1011; tick(10);
    check("bounce_held", {key_interrupt, key_state}, 8'h04);
    col = 4'b1111; tick(2);
    col = 4'b1011; tick(1);
    col = 4'b1111;
    tick(6); check("bounce_fall5", {key_interrupt, key_state}, 8'h04);
    tick(1); check("bounce_fall6", {key_interrupt, key_state}, 8'h00);
    check("bounce_pulses", 8'(pulses[2] - p1), 8'h01);
    tick(3);

    // All four keys at once.
    col = 4'b0000;
    tick(6); check("simul_edge5", {key_interrupt, key_state}, 8'h00);
    tick(1); check("simul_edge6", {key_interrupt, key_state}, 8'hFF);
    tick(1); check("simul_edge7", {key_interrupt, key_state}, 8'h0F);
    col = 4'b1111; tick(10);
    check("simul_released", {key_interrupt, key_state}, 8'h00);

    // Reset mid-press, release reset with key held, then reset mid-hold.
    col = 4'b1110; tick(5);
    HRESETn = 1'b0; #1;
    check("reset_mid_press", {key_interrupt, key_state}, 8'h00);
    tick(2);
    HRESETn = 1'b1;
    tick(6); check("repress_edge5", {key_interrupt, key_state}, 8'h00);
    tick(1); check("repress_edge6", {key_interrupt, key_state}, 8'h11);
    tick(2); check("repress_held", {key_interrupt, key_state}, 8'h01);
    HRESETn = 1'b0; #1;
    check("reset_mid_hold", {key_interrupt, key_state}, 8'h00);
    tick(2);
    col = 4'b1111; HRESETn = 1'b1;
    tick(10);

    // Key 3 held 30 cycles after its press pulse.
    p2 = pulses[3];
    col = 4'b0111;
    tick(7); check("rpt_press", {key_interrupt, key_state}, 8'h88);
    tick(9); check("rpt_p9", {key_interrupt, key_state}, 8'h08);
    tick(1); check("rpt_p10", {key_interrupt, key_state}, RPT_ON ? 8'h88 : 8'h08);
    tick(20); #1;
    check("rpt_pulses", 8'(pulses[3] - p2), RPT_ON ? 8'h06 : 8'h01);
    col = 4'b1111; tick(10);
    check("rpt_released", {key_interrupt, key_state}, 8'h00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
